// File: rtl/dn_cfg_sequencer_pkg.sv
// Shared definitions for the Benes distribution-network control stage:
// default geometry, FSM state type and per-switch route codes.
package dn_pkg;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default geometry (N=64 ports, 64-bit config beats).
    localparam int unsigned DN_N      = 64;
    localparam int unsigned DN_LEVELS = 2 * $clog2(DN_N) - 1;
    localparam int unsigned DN_CFG_W  = 64;
    localparam int unsigned RS_W      = (DN_LEVELS - 1) * DN_N;
    localparam int unsigned NBEATS    = RS_W / DN_CFG_W;
    localparam int unsigned BCNT_W    = cnt_w(NBEATS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SET,
        STREAM,
        DRAIN
    } dn_state_t;

    // Two-bit switch setting codes.
    localparam logic [1:0] SW_PASS    = 2'b00;
    localparam logic [1:0] SW_CROSS   = 2'b01;
    localparam logic [1:0] SW_BCAST_U = 2'b10;
    localparam logic [1:0] SW_BCAST_L = 2'b11;

endpackage

// File: rtl/dn_cfg_sequencer_valid_pipe.sv
// Enable-gated 1-bit valid shift line that mirrors the DN pipeline.
// o_empty reports the line contents as they will be after this cycle's
// update, so the drain logic can leave on the cycle the last bit exits.
module dn_valid_pipe
    import dn_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_din,
    output logic o_tap,
    output logic o_empty
);

    logic [DEPTH-1:0] r_line;
    logic [DEPTH-1:0] w_next;

    assign w_next  = i_en ? ((r_line << 1) | DEPTH'(i_din)) : r_line;
    assign o_tap   = r_line[DEPTH-1];
    assign o_empty = (w_next == '0);

    // Shift the line only when the DN advances; hold during stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= '0;
        end else begin
            r_line <= w_next;
        end
    end

endmodule

// File: rtl/dn_cfg_sequencer.sv
// Upstream control stage of the Benes distribution network: assembles the
// switch-setting vector from config beats, pulses set_en, streams operand
// vectors with route_en and tracks DN latency for dn_out_valid.
module dn_cfg_sequencer
    import dn_pkg::*;
#(
    parameter int unsigned N        = 64,
    parameter int unsigned DW_DATA  = 8,
    parameter int unsigned N_LEVELS = 2 * $clog2(N) - 1,
    parameter int unsigned CFG_W    = 64,
    parameter int unsigned DN_LAT   = N_LEVELS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [CFG_W-1:0]            cfg_data,
    input  logic                        cfg_last,
    input  logic                        vec_valid,
    output logic                        vec_ready,
    input  logic [DW_DATA*N-1:0]        vec_data,
    input  logic                        vec_last,
    output logic                        set_en,
    output logic                        route_en,
    output logic [(N_LEVELS-1)*N-1:0]   route_signals,
    output logic [DW_DATA*N-1:0]        dn_in,
    output logic                        dn_out_valid,
    output logic                        busy,
    output logic                        cfg_err
);

    localparam int unsigned LP_RS_W   = (N_LEVELS - 1) * N;
    localparam int unsigned LP_NBEATS = LP_RS_W / CFG_W;
    localparam int unsigned LP_CNT_W  = cnt_w(LP_NBEATS);
    localparam logic [LP_CNT_W-1:0] LP_LAST_BEAT = LP_CNT_W'(LP_NBEATS - 1);

    dn_state_t              r_state;
    dn_state_t              w_state_nxt;
    logic [LP_CNT_W-1:0]    r_beat_cnt;
    logic [LP_RS_W-1:0]     r_route_signals;
    logic [DW_DATA*N-1:0]   r_dn_in;
    logic                   r_route_en;
    logic                   r_cfg_err;

    logic                   w_cfg_acc;
    logic                   w_vec_acc;
    logic                   w_last_beat;
    logic                   w_adv;
    logic                   w_tap;
    logic                   w_pipe_empty;

    assign cfg_ready     = (r_state == IDLE) || (r_state == LOAD);
    assign vec_ready     = (r_state == STREAM);
    assign set_en        = (r_state == SET);
    assign busy          = (r_state != IDLE);
    assign route_en      = r_route_en;
    assign route_signals = r_route_signals;
    assign dn_in         = r_dn_in;
    assign cfg_err       = r_cfg_err;

    assign w_cfg_acc   = cfg_valid & cfg_ready;
    assign w_vec_acc   = vec_valid & vec_ready;
    assign w_last_beat = (r_beat_cnt == LP_LAST_BEAT);
    // The DN advances on every accepted vector and on every drain cycle.
    assign w_adv       = w_vec_acc | (r_state == DRAIN);

    // Only report a tap bit while the DN is actually advancing, so a bit
    // parked at the tap during a stall is not counted twice.
    assign dn_out_valid = w_tap & r_route_en;

    dn_valid_pipe #(
        .DEPTH (DN_LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_adv),
        .i_din   (w_vec_acc),
        .o_tap   (w_tap),
        .o_empty (w_pipe_empty)
    );

    // Next-state selection for the load/set/stream/drain sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, LOAD: if (w_cfg_acc) w_state_nxt = w_last_beat ? SET : LOAD;
            SET:        w_state_nxt = STREAM;
            STREAM:     if (w_vec_acc && vec_last) w_state_nxt = DRAIN;
            DRAIN:      if (w_pipe_empty) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat counter, config register and sticky framing-error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat_cnt      <= '0;
            r_route_signals <= {(LP_RS_W / 2){SW_PASS}};
            r_cfg_err       <= 1'b0;
        end else if (w_cfg_acc) begin
            for (int unsigned b = 0; b < LP_NBEATS; b++) begin
                if (r_beat_cnt == LP_CNT_W'(b)) begin
                    r_route_signals[b*CFG_W +: CFG_W] <= cfg_data;
                end
            end
            if (w_last_beat) begin
                r_beat_cnt <= '0;
                if (!cfg_last) r_cfg_err <= 1'b1;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (cfg_last) r_cfg_err <= 1'b1;
            end
        end
    end

    // Operand register and registered DN advance strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dn_in    <= '0;
            r_route_en <= 1'b0;
        end else begin
            r_route_en <= w_adv;
            if (w_vec_acc) r_dn_in <= vec_data;
        end
    end

endmodule

// File: tb/tb_dn_cfg_sequencer.sv
// Directed bench for dn_cfg_sequencer at N=8, CFG_W=8 (40-bit route vector,
// five beats), DN_LAT=5. A negedge monitor keeps a scoreboard of accepted
// vectors and checks operand capture and output-valid timing.
module tb_dn_cfg_sequencer;

    localparam int unsigned TN    = 8;
    localparam int unsigned TDW   = 8;
    localparam int unsigned TLEV  = 6;
    localparam int unsigned TCW   = 8;
    localparam int unsigned TLAT  = 5;
    localparam int unsigned TRS_W = (TLEV - 1) * TN;
    localparam int unsigned TVW   = TDW * TN;

    logic               clk;
    logic               rst_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [TCW-1:0]     cfg_data;
    logic               cfg_last;
    logic               vec_valid;
    logic               vec_ready;
    logic [TVW-1:0]     vec_data;
    logic               vec_last;
    logic               set_en;
    logic               route_en;
    logic [TRS_W-1:0]   route_signals;
    logic [TVW-1:0]     dn_in;
    logic               dn_out_valid;
    logic               busy;
    logic               cfg_err;

    int n_asrt = 0;
    int n_fail = 0;

    // Monitor state: route_en / set_en / dn_out_valid counts and scoreboard.
    int unsigned rcnt  = 0;
    int unsigned scnt  = 0;
    int unsigned ovcnt = 0;
    int unsigned q_rc[$];
    logic [TVW-1:0] q_d[$];
    bit prev_acc = 0;
    int unsigned m_exp;
    logic [TVW-1:0] m_dat;

    dn_cfg_sequencer #(
        .N        (TN),
        .DW_DATA  (TDW),
        .N_LEVELS (TLEV),
        .CFG_W    (TCW),
        .DN_LAT   (TLAT)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
        .cfg_last      (cfg_last),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready),
        .vec_data      (vec_data),
        .vec_last      (vec_last),
        .set_en        (set_en),
        .route_en      (route_en),
        .route_signals (route_signals),
        .dn_in         (dn_in),
        .dn_out_valid  (dn_out_valid),
        .busy          (busy),
        .cfg_err       (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_rc.delete();
            q_d.delete();
            prev_acc = 0;
        end else begin
            if (route_en) rcnt++;
            if (set_en) scnt++;
            if (prev_acc) begin
                m_dat = q_d.pop_front();
                check("route_en_after_accept", route_en, 1);
                check("dn_in_capture", dn_in, m_dat);
            end
            if (dn_out_valid) begin
                ovcnt++;
                check("dn_out_valid_expected", q_rc.size() != 0, 1);
                if (q_rc.size() != 0) begin
                    m_exp = q_rc.pop_front();
                    check("dn_out_valid_timing", rcnt, m_exp);
                end
            end
            prev_acc = vec_valid & vec_ready;
            if (prev_acc) begin
                q_rc.push_back(rcnt + TLAT);
                q_d.push_back(vec_data);
            end
        end
    end

    // Five beats base+0..base+4; cfg_last on beat last_pos (-1: never).
    task automatic send_cfg(input logic [7:0] base, input int last_pos);
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = base + 8'(i);
            cfg_last  = (i == last_pos);
            @(negedge clk);
            check("cfg_ready_load", cfg_ready, 1);
            @(posedge clk); #2;
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic send_vecs(input int n);
        for (int i = 0; i < n; i++) begin
            vec_valid = 1'b1;
            vec_data  = {$urandom, $urandom};
            vec_last  = (i == n - 1);
            @(posedge clk); #2;
        end
        vec_valid = 1'b0;
        vec_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        check(tag, busy, 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        int k;
        int unsigned rc0, oc0, sc0;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
        vec_valid = 1'b0; vec_data = '0; vec_last = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_set_en", set_en, 0);
        check("rst_route_en", route_en, 0);
        check("rst_dn_out_valid", dn_out_valid, 0);
        check("rst_route_signals", route_signals, 0);
        check("rst_dn_in", dn_in, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_vec_ready", vec_ready, 0);
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #2;

        // Test 1/2: clean config, four back-to-back vectors
        rc0 = rcnt; oc0 = ovcnt; sc0 = scnt;
        send_cfg(8'h01, 4);
        @(negedge clk);
        check("t1_set_en", set_en, 1);
        check("t1_route_signals", route_signals, 64'h0504030201);
        check("t1_cfg_err", cfg_err, 0);
        check("t1_cfg_ready_set", cfg_ready, 0);
        check("t1_vec_ready_set", vec_ready, 0);
        @(negedge clk);
        check("t1_set_en_drop", set_en, 0);
        check("t1_vec_ready", vec_ready, 1);
        @(posedge clk); #2;
        send_vecs(4);
        wait_idle("t2_idle");
        check("t2_route_en_cycles", rcnt - rc0, 4 + TLAT);
        check("t2_out_valid_cycles", ovcnt - oc0, 4);
        check("t2_set_pulses", scnt - sc0, 1);

        // Test 3: gap between vectors
        rc0 = rcnt; oc0 = ovcnt;
        send_cfg(8'h10, 4);
        @(negedge clk);
        check("t3_route_signals", route_signals, 64'h1413121110);
        @(posedge clk); #2;
        vec_valid = 1'b1; vec_data = {$urandom, $urandom}; vec_last = 1'b0;
        @(posedge clk); #2;
        vec_valid = 1'b0;
        @(negedge clk);
        check("t3_route_en_1", route_en, 1);
        @(posedge clk); #2;
        vec_valid = 1'b1; vec_data = {$urandom, $urandom}; vec_last = 1'b1;
        @(negedge clk);
        check("t3_route_en_0", route_en, 0);
        @(posedge clk); #2;
        vec_valid = 1'b0; vec_last = 1'b0;
        @(negedge clk);
        check("t3_route_en_1b", route_en, 1);
        wait_idle("t3_idle");
        check("t3_route_en_cycles", rcnt - rc0, 2 + TLAT);
        check("t3_out_valid_cycles", ovcnt - oc0, 2);

        // Test 4: early cfg_last, sticky error over three more passes
        send_cfg(8'h20, 2);
        @(negedge clk);
        check("t4_cfg_err", cfg_err, 1);
        check("t4_set_en", set_en, 1);
        check("t4_route_signals", route_signals, 64'h2423222120);
        @(posedge clk); #2;
        send_vecs(1);
        wait_idle("t4_idle");
        for (int p = 0; p < 3; p++) begin
            send_cfg(8'h30 + 8'(p * 16), 4);
            @(negedge clk);
            check("t4_pass_set_en", set_en, 1);
            check("t4_pass_cfg_err", cfg_err, 1);
            @(posedge clk); #2;
            send_vecs(2);
            wait_idle("t4_pass_idle");
            check("t4_pass_cfg_err_idle", cfg_err, 1);
        end

        // Test 5: asynchronous reset mid-stream
        send_cfg(8'h40, 4);
        @(negedge clk);
        check("t5_set_en", set_en, 1);
        @(posedge clk); #2;
        vec_valid = 1'b1; vec_data = {$urandom, $urandom}; vec_last = 1'b0;
        @(posedge clk); #2;
        vec_data = {$urandom, $urandom};
        @(posedge clk); #1;
        vec_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_set_en", set_en, 0);
        check("t5_route_en", route_en, 0);
        check("t5_dn_out_valid", dn_out_valid, 0);
        check("t5_route_signals", route_signals, 0);
        check("t5_dn_in", dn_in, 0);
        check("t5_cfg_err", cfg_err, 0);
        check("t5_busy", busy, 0);
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #2;
        rc0 = rcnt; oc0 = ovcnt;
        send_cfg(8'hA1, 4);
        @(negedge clk);
        check("t5_clean_route_signals", route_signals, 64'hA5A4A3A2A1);
        check("t5_clean_cfg_err", cfg_err, 0);
        check("t5_clean_set_en", set_en, 1);
        @(posedge clk); #2;
        send_vecs(3);
        wait_idle("t5_idle");
        check("t5_route_en_cycles", rcnt - rc0, 3 + TLAT);
        check("t5_out_valid_cycles", ovcnt - oc0, 3);

        // Missing cfg_last on the final beat: error but still proceeds
        send_cfg(8'h50, -1);
        @(negedge clk);
        check("t5_nolast_cfg_err", cfg_err, 1);
        check("t5_nolast_set_en", set_en, 1);
        @(posedge clk); #2;

        // Test 6: cfg_valid held through stream/drain
        cfg_valid = 1'b1; cfg_data = 8'hFF; cfg_last = 1'b1;
        send_vecs(2);
        k = 0;
        @(negedge clk);
        while (busy && k < 60) begin
            check("t6_cfg_ready", cfg_ready, 0);
            check("t6_route_signals", route_signals, 64'h5453525150);
            @(negedge clk);
            k++;
        end
        check("t6_idle", busy, 0);
        check("t6_route_signals_idle", route_signals, 64'h5453525150);
        @(posedge clk); #2;
        cfg_valid = 1'b0; cfg_last = 1'b0;
        @(negedge clk);
        check("t6_load_busy", busy, 1);
        check("t6_beat0_written", route_signals, 64'h54535251FF);
        check("t6_scoreboard_empty", q_rc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
